// File: rtl/infra_reset_seq.sv
// Staged reset sequencer: waits for MMCM lock and IDELAYCTRL ready, then releases
// per-stage resets in ascending order, each after a gap and the previous stage's ack.
module infra_reset_seq #(
  parameter int unsigned NUM_STAGES  = 4,
  parameter int unsigned GAP_CYCLES  = 256,
  parameter int unsigned ACK_TIMEOUT = 65535,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  pll_lock,
  input  logic                  idelay_rdy,
  input  logic [NUM_STAGES-1:0] stage_ack,
  output logic [NUM_STAGES-1:0] stage_rst,
  output logic                  all_ready,
  output logic                  timeout_err,
  output logic [2:0]            fault_stage,
  output logic [7:0]            relock_count
);

  localparam int unsigned CNT_W    = 16;
  localparam int unsigned IDX_W    = 3;
  localparam int unsigned RELOCK_W = 8;
  localparam int unsigned ACK_W    = 8;

  localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(ACK_TIMEOUT);
  localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(NUM_STAGES - 1);

  typedef enum logic [2:0] {
    S_HOLD,
    S_WAIT_IDELAY,
    S_GAP,
    S_WAIT_ACK,
    S_RUN,
    S_ERROR
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [IDX_W-1:0]      r_idx, w_idx_nxt;
  logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
  logic [NUM_STAGES-1:0] r_stage_rst, w_stage_rst_nxt;
  logic                  r_all_ready, w_all_ready_nxt;
  logic                  r_timeout_err, w_timeout_err_nxt;
  logic [IDX_W-1:0]      r_fault_stage, w_fault_stage_nxt;
  logic [RELOCK_W-1:0]   r_relock, w_relock_nxt;

  logic [SYNC_STAGES-1:0] r_lock_sync;
  logic [SYNC_STAGES-1:0] r_idly_sync;
  logic                   w_lock_s;
  logic                   w_idelay_s;
  logic [ACK_W-1:0]       w_ack_ext;
  logic                   w_ack;
  logic                   w_lock_lost;

  // Input synchronisers for the asynchronous lock/ready levels
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_lock_sync <= '0;
      r_idly_sync <= '0;
    end else begin
      r_lock_sync <= {r_lock_sync[SYNC_STAGES-2:0], pll_lock};
      r_idly_sync <= {r_idly_sync[SYNC_STAGES-2:0], idelay_rdy};
    end
  end

  assign w_lock_s    = r_lock_sync[SYNC_STAGES-1];
  assign w_idelay_s  = r_idly_sync[SYNC_STAGES-1];
  assign w_ack_ext   = ACK_W'(stage_ack);
  assign w_ack       = w_ack_ext[r_idx];
  assign w_lock_lost = !w_lock_s &&
                       (r_state inside {S_WAIT_IDELAY, S_GAP, S_WAIT_ACK, S_RUN});

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state       <= S_HOLD;
      r_idx         <= '0;
      r_cnt         <= '0;
      r_stage_rst   <= '1;
      r_all_ready   <= 1'b0;
      r_timeout_err <= 1'b0;
      r_fault_stage <= '0;
      r_relock      <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_idx         <= w_idx_nxt;
      r_cnt         <= w_cnt_nxt;
      r_stage_rst   <= w_stage_rst_nxt;
      r_all_ready   <= w_all_ready_nxt;
      r_timeout_err <= w_timeout_err_nxt;
      r_fault_stage <= w_fault_stage_nxt;
      r_relock      <= w_relock_nxt;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_idx_nxt         = r_idx;
    w_cnt_nxt         = r_cnt;
    w_stage_rst_nxt   = r_stage_rst;
    w_all_ready_nxt   = r_all_ready;
    w_timeout_err_nxt = r_timeout_err;
    w_fault_stage_nxt = r_fault_stage;
    w_relock_nxt      = r_relock;

    case (r_state)
      S_HOLD: begin
        w_stage_rst_nxt = '1;
        w_all_ready_nxt = 1'b0;
        if (w_lock_s) w_state_nxt = S_WAIT_IDELAY;
      end
      S_WAIT_IDELAY: begin
        if (w_idelay_s) begin
          w_state_nxt = S_GAP;
          w_idx_nxt   = '0;
          w_cnt_nxt   = '0;
        end
      end
      S_GAP: begin
        if (r_cnt == GAP_LAST) begin
          w_stage_rst_nxt = r_stage_rst & ~(NUM_STAGES'(1) << r_idx);
          w_state_nxt     = S_WAIT_ACK;
          w_cnt_nxt       = '0;
        end else begin
          w_cnt_nxt = CNT_W'(r_cnt + CNT_W'(1));
        end
      end
      S_WAIT_ACK: begin
        if (w_ack) begin
          if (r_idx == IDX_LAST) begin
            w_state_nxt     = S_RUN;
            w_all_ready_nxt = 1'b1;
          end else begin
            w_idx_nxt   = IDX_W'(r_idx + IDX_W'(1));
            w_state_nxt = S_GAP;
            w_cnt_nxt   = '0;
          end
        end else if (r_cnt == TIMEOUT_CNT) begin
          w_state_nxt       = S_ERROR;
          w_timeout_err_nxt = 1'b1;
          w_fault_stage_nxt = r_idx;
          w_stage_rst_nxt   = '1;
        end else begin
          w_cnt_nxt = CNT_W'(r_cnt + CNT_W'(1));
        end
      end
      S_RUN: begin
        w_stage_rst_nxt = '0;
        w_all_ready_nxt = 1'b1;
      end
      S_ERROR: begin
        w_stage_rst_nxt = '1;
        w_all_ready_nxt = 1'b0;
      end
      default: begin
        w_state_nxt     = S_HOLD;
        w_stage_rst_nxt = '1;
        w_all_ready_nxt = 1'b0;
      end
    endcase

    // Lock loss overrides any ack or timeout decision taken on the same edge
    if (w_lock_lost) begin
      w_state_nxt     = S_HOLD;
      w_idx_nxt       = '0;
      w_cnt_nxt       = '0;
      w_stage_rst_nxt = '1;
      w_all_ready_nxt = 1'b0;
      if (r_relock != '1) w_relock_nxt = RELOCK_W'(r_relock + RELOCK_W'(1));
    end
  end

  assign stage_rst    = r_stage_rst;
  assign all_ready    = r_all_ready;
  assign timeout_err  = r_timeout_err;
  assign fault_stage  = r_fault_stage;
  assign relock_count = r_relock;

endmodule

// File: tb/tb_infra_reset_seq.sv
// Directed bench for infra_reset_seq: nominal sequencing, late IDELAY, ack timeout,
// lock loss and relock, relock_count saturation, lock-vs-ack priority, async reset.
module tb_infra_reset_seq;

  localparam int unsigned NS = 4;

  logic          sys_clk = 1'b0;
  logic          sys_rst_n;
  logic          pll_lock;
  logic          idelay_rdy;
  logic [NS-1:0] stage_ack;
  logic [NS-1:0] stage_rst;
  logic          all_ready;
  logic          timeout_err;
  logic [2:0]    fault_stage;
  logic [7:0]    relock_count;

  int n_checks = 0;
  int n_errors = 0;

  infra_reset_seq #(
    .NUM_STAGES (NS),
    .GAP_CYCLES (4),
    .ACK_TIMEOUT(10),
    .SYNC_STAGES(2)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .pll_lock    (pll_lock),
    .idelay_rdy  (idelay_rdy),
    .stage_ack   (stage_ack),
    .stage_rst   (stage_rst),
    .all_ready   (all_ready),
    .timeout_err (timeout_err),
    .fault_stage (fault_stage),
    .relock_count(relock_count)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  // Expected stage_rst at edge e (edge 1 = first edge sampling lock_s=1), ack high
  function automatic logic [NS-1:0] exp_rst(input int e);
    logic [NS-1:0] r;
    for (int i = 0; i < NS; i++) r[i] = (e < 6 + 5 * i);
    return r;
  endfunction

  task automatic do_reset();
    pll_lock   = 1'b0;
    idelay_rdy = 1'b0;
    stage_ack  = '1;
    sys_rst_n  = 1'b0;
    tick(2);
    sys_rst_n  = 1'b1;
    tick(1);
  endtask

  // Caller raises pll_lock right after a tick; two edges pass before lock_s=1
  task automatic run_nominal(input string pfx);
    tick(2);
    for (int e = 1; e <= 24; e++) begin
      tick(1);
      check($sformatf("%s_rst_e%0d", pfx, e), 32'(stage_rst), 32'(exp_rst(e)));
      check($sformatf("%s_rdy_e%0d", pfx, e), 32'(all_ready), 32'(e >= 22));
    end
    check({pfx, "_tmo"}, 32'(timeout_err), 32'(0));
  endtask

  initial begin
    sys_rst_n  = 1'b0;
    pll_lock   = 1'b0;
    idelay_rdy = 1'b0;
    stage_ack  = '1;
    tick(2);

    // Reset values
    check("rst_stage_rst", 32'(stage_rst), 32'hF);
    check("rst_all_ready", 32'(all_ready), 32'(0));
    check("rst_timeout", 32'(timeout_err), 32'(0));
    check("rst_fault", 32'(fault_stage), 32'(0));
    check("rst_relock", 32'(relock_count), 32'(0));
    sys_rst_n = 1'b1;
    tick(3);
    check("hold_no_lock", 32'(stage_rst), 32'hF);

    // Nominal
    pll_lock   = 1'b1;
    idelay_rdy = 1'b1;
    run_nominal("nom");

    // Lock loss in RUN and relock
    pll_lock = 1'b0;
    tick(2);
    check("ll_pre_rst", 32'(stage_rst), 32'h0);
    check("ll_pre_rdy", 32'(all_ready), 32'(1));
    tick(1);
    check("ll_rst", 32'(stage_rst), 32'hF);
    check("ll_rdy", 32'(all_ready), 32'(0));
    check("ll_relock", 32'(relock_count), 32'(1));
    pll_lock = 1'b1;
    run_nominal("relock");

    // Async reset mid-GAP (stage 1 gap)
    pll_lock = 1'b0;
    tick(3);
    check("ar_relock2", 32'(relock_count), 32'(2));
    pll_lock = 1'b1;
    tick(2 + 8);
    check("ar_gap_rst", 32'(stage_rst), 32'hE);
    #2;
    sys_rst_n = 1'b0;
    #1;
    check("ar_stage_rst", 32'(stage_rst), 32'hF);
    check("ar_relock", 32'(relock_count), 32'(0));
    check("ar_rdy", 32'(all_ready), 32'(0));
    do_reset();

    // IDELAY late by 50 cycles
    pll_lock = 1'b1;
    tick(2);
    for (int c = 0; c < 50; c++) begin
      tick(1);
      check($sformatf("idl_hold_c%0d", c), 32'(stage_rst), 32'hF);
    end
    idelay_rdy = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      tick(1);
      check($sformatf("idl_rel_e%0d", e), 32'(stage_rst), (e >= 7) ? 32'hE : 32'hF);
    end
    do_reset();

    // Ack timeout on stage 2
    stage_ack  = 4'b1011;
    pll_lock   = 1'b1;
    idelay_rdy = 1'b1;
    tick(2 + 26);
    check("to_pre_rst", 32'(stage_rst), 32'h8);
    check("to_pre_err", 32'(timeout_err), 32'(0));
    tick(1);
    check("to_err", 32'(timeout_err), 32'(1));
    check("to_fault", 32'(fault_stage), 32'(2));
    check("to_rst", 32'(stage_rst), 32'hF);
    check("to_rdy", 32'(all_ready), 32'(0));
    pll_lock = 1'b0;
    tick(5);
    check("to_lockdn_rst", 32'(stage_rst), 32'hF);
    check("to_lockdn_relock", 32'(relock_count), 32'(0));
    pll_lock = 1'b1;
    tick(30);
    check("to_lockup_rst", 32'(stage_rst), 32'hF);
    check("to_lockup_err", 32'(timeout_err), 32'(1));
    check("to_lockup_rdy", 32'(all_ready), 32'(0));
    do_reset();

    // Lock loss coincident with ack in WAIT_ACK
    stage_ack  = 4'b1110;
    pll_lock   = 1'b1;
    idelay_rdy = 1'b1;
    tick(2 + 6);
    check("pri_rel0", 32'(stage_rst), 32'hE);
    pll_lock = 1'b0;
    tick(2);
    check("pri_wait", 32'(stage_rst), 32'hE);
    stage_ack = '1;
    tick(1);
    check("pri_rst", 32'(stage_rst), 32'hF);
    check("pri_relock", 32'(relock_count), 32'(1));
    tick(3);
    check("pri_hold", 32'(stage_rst), 32'hF);
    do_reset();

    // relock_count saturation
    for (int i = 0; i < 300; i++) begin
      pll_lock = 1'b1;
      tick(4);
      pll_lock = 1'b0;
      tick(4);
      if (i == 0)   check("sat_1", 32'(relock_count), 32'(1));
      if (i == 254) check("sat_255", 32'(relock_count), 32'(255));
    end
    check("sat_300", 32'(relock_count), 32'(255));
    check("sat_rst", 32'(stage_rst), 32'hF);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
